fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction memory. It issues one fetch request at a time, waits for the response, and presents the instruction to decode through a valid/ready handshake. It applies branch/jump redirects from execute at any point, squashing stale in-flight fetches. It sits between execute (redirect source), instruction memory and decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  execute requests PC change (branch taken / jump).
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals current PC.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  response instruction.
- instr_valid_o  out  1  instruction available to decode.
- instr_o  out  32  latched instruction.
- instr_pc_o  out  32  PC of instr_o.
- instr_ready_i  in  1  decode accepts instruction.
- misalign_o  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0.

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. At most one outstanding memory request.
- IDLE: entered on reset; unconditionally -> REQ next cycle.
- REQ: imem_req_o=1, imem_addr_o=pc.
  - redirect_i: pc<=target; gnt same cycle -> DROP (granted fetch is stale), else stay REQ.
  - else gnt -> WAIT.
- WAIT: imem_req_o=0.
  - redirect_i: pc<=target; rvalid same cycle -> REQ (data discarded), else -> DROP.
  - else rvalid: instr_o<=rdata, instr_pc_o<=pc, pc<=pc+4, -> HOLD.
- DROP: discard the next rvalid, then -> REQ. Redirect in DROP updates pc, stays DROP (still awaiting the stale response).
- HOLD: instr_valid_o=1; instr_o/instr_pc_o stable.
  - redirect_i: pc<=target, valid deasserts next cycle, -> REQ (redirect wins over ready).
  - else instr_ready_i: -> REQ.
- Redirect target: bits [1:0] forced to 00 before loading pc; misalign_o=1 the cycle after if either was set.
- pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- imem_rvalid_i outside WAIT/DROP is ignored.

## Timing
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, instr_o=0, instr_pc_o=0, misalign_o=0. Thus imem_req_o=0 and instr_valid_o=0.
- First request: imem_req_o high in the second cycle after rst deasserts.
- imem_req_o, imem_addr_o and instr_valid_o are decoded combinationally from state/pc registers. They are never from inputs.
- The address is stable while req && !gnt, except when a redirect occurs. In that case the address changes the next cycle.
- Minimum fetch latency: gnt in the REQ cycle, rvalid in the first WAIT cycle, so instr_valid_o is high on cycle 3. Best throughput: 1 instruction per 3 cycles.
- Redirect latency: the new address appears on imem_addr_o the cycle after redirect_i, or after the stale response drains in DROP.
- Reset asserted mid-transaction aborts immediately. Any later response from the memory is the memory's responsibility and requires a memory reset.

## Structure
- Package fetch_pkg: state enum fetch_state_t {IDLE, REQ, WAIT, DROP, HOLD}; localparam INSTR_BYTES=4.
- Single module, no sub-module.
- The PC register and the next-PC mux (redirect / +4 / hold) are internal.

## Test plan
- Reset release, RESET_PC=32'h100, gnt and rvalid immediate, ready=1: addresses 0x100, 0x104, 0x108 on consecutive REQ cycles. instr_pc_o matches, and valid is high every 3rd cycle.
- Backpressure: ready=0 for 5 cycles in HOLD. instr_o/instr_pc_o stay stable, no new imem_req_o, and fetch resumes at pc+4 after ready.
- Redirect in WAIT to 0x200, rvalid 2 cycles later: that response is dropped, the next request address is 0x200, and instr_valid_o is never asserted for the stale data.
- Redirect coincident with gnt in REQ: the state goes to DROP, one response is discarded, then a request to the target is made.
- Redirect to 0x203: pc loads 0x200, misalign_o pulses one cycle, and fetch proceeds at 0x200. Also cover redirect to 0xFFFF_FFFC: the following fetch is at 0x0.
- rst asserted during WAIT: the outputs return to their reset values asynchronously, and after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t  sequencer state encoding
//   INSTR_BYTES    PC increment per fetched instruction
//   align_pc()     clears the byte-offset bits of a redirect target
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DROP,
        HOLD
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, issues one imem
// request at a time, hands the returned instruction to decode over a
// valid/ready handshake and applies execute redirects at any time, dropping
// the response of any fetch made stale by a redirect.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   redirect_i/_pc_i      redirect request and target from execute
//   imem_req_o/addr_o     fetch request and address (address = pc)
//   imem_gnt_i            memory accepted the request
//   imem_rvalid_i/rdata_i memory response
//   instr_valid_o/o/pc_o  instruction to decode and its PC
//   instr_ready_i         decode accepts the instruction
//   misalign_o            one-cycle pulse: redirect target was not word aligned
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | request driven at pc, waiting for grant
// WAIT  | granted, waiting for the response
// DROP  | a stale response is still owed by memory; discard it
// HOLD  | instruction presented to decode, waiting for ready
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        misalign_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_o    <= 32'h0;
            instr_pc_o <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            misalign_o <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
            if (capture) begin
                instr_o    <= imem_rdata_i;
                instr_pc_o <= pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_i) begin
                    // A grant in the redirect cycle still leaves a response in flight.
                    state_nxt = imem_gnt_i ? DROP : REQ;
                end else if (imem_gnt_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_nxt = imem_rvalid_i ? REQ : DROP;
                end else if (imem_rvalid_i) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + 32'(INSTR_BYTES);
                    state_nxt = HOLD;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect always wins the PC mux, whatever the state.
        if (redirect_i) begin
            pc_nxt = align_pc(redirect_pc_i);
        end
    end

    assign imem_req_o    = (state == REQ);
    assign imem_addr_o   = pc;
    assign instr_valid_o = (state == HOLD);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] RP = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    // Reference model: PC plus flags describing the fetch in progress.
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_start, m_inflight, m_stale, m_have, m_mis;

    fetch_ctrl #(.RESET_PC(RP)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = RP;
        m_start    = 1'b1;
        m_inflight = 1'b0;
        m_stale    = 1'b0;
        m_have     = 1'b0;
        m_mis      = 1'b0;
        m_instr    = 32'h0;
        m_ipc      = 32'h0;
    endtask

    task automatic model_step(input logic redir, input logic [31:0] tgt, input logic gnt,
                              input logic rv, input logic [31:0] rd, input logic rdy);
        logic [31:0] npc;
        npc = m_pc;
        if (m_start) begin
            m_start = 1'b0;
        end else if (m_have) begin
            if (redir || rdy) m_have = 1'b0;
        end else if (m_inflight) begin
            if (rv) begin
                m_inflight = 1'b0;
                if (!m_stale && !redir) begin
                    m_instr = rd;
                    m_ipc   = m_pc;
                    npc     = m_pc + 32'd4;
                    m_have  = 1'b1;
                end
                m_stale = 1'b0;
            end else if (redir) begin
                m_stale = 1'b1;
            end
        end else if (gnt) begin
            m_inflight = 1'b1;
            m_stale    = redir;
        end
        if (redir) npc = tgt & 32'hFFFF_FFFC;
        m_mis = redir && (tgt[1:0] != 2'b00);
        m_pc  = npc;
    endtask

    task automatic check_outputs();
        chk("imem_req",    32'(imem_req_o),    32'(!m_start && !m_inflight && !m_have));
        chk("imem_addr",   imem_addr_o,        m_pc);
        chk("instr_valid", 32'(instr_valid_o), 32'(m_have));
        chk("instr",       instr_o,            m_instr);
        chk("instr_pc",    instr_pc_o,         m_ipc);
        chk("misalign",    32'(misalign_o),    32'(m_mis));
    endtask

    // One clock: check current outputs, drive inputs, advance model and DUT.
    task automatic cycle(input logic redir, input logic [31:0] tgt, input logic gnt,
                         input logic rv, input logic [31:0] rd, input logic rdy);
        check_outputs();
        redirect_i    = redir;
        redirect_pc_i = tgt;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        instr_ready_i = rdy;
        model_step(redir, tgt, gnt, rv, rd, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_req", 32'(imem_req_o), 32'h0);
        rst = 1'b1;

        // Streaming with immediate grant/response and ready.
        chk("idle_no_req", 32'(imem_req_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("stream_req",  32'(imem_req_o), 32'h1);
            chk("stream_addr", imem_addr_o, RP + 32'(4 * k));
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0DE_0000 + 32'(k), 1'b1);
            chk("stream_wait_valid", 32'(instr_valid_o), 32'h0);
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hC0DE_0000 + 32'(k), 1'b1);
            chk("stream_valid", 32'(instr_valid_o), 32'h1);
            chk("stream_ipc",   instr_pc_o, RP + 32'(4 * k));
            chk("stream_instr", instr_o, 32'hC0DE_0000 + 32'(k));
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        end

        // Backpressure in HOLD.
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hBEEF_0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(instr_valid_o), 32'h1);
            chk("bp_req",   32'(imem_req_o), 32'h0);
            chk("bp_instr", instr_o, 32'hBEEF_0001);
            chk("bp_ipc",   instr_pc_o, 32'h0000_010C);
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("bp_resume_addr", imem_addr_o, 32'h0000_0110);
        chk("bp_resume_req",  32'(imem_req_o), 32'h1);

        // Redirect in WAIT, stale response two cycles later.
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rw_valid0", 32'(instr_valid_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rw_valid1", 32'(instr_valid_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_DEAD, 1'b1);
        chk("rw_valid2", 32'(instr_valid_o), 32'h0);
        chk("rw_addr",   imem_addr_o, 32'h0000_0200);
        chk("rw_req",    32'(imem_req_o), 32'h1);

        // Redirect coincident with grant.
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rg_drop_req", 32'(imem_req_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0002, 1'b1);
        chk("rg_addr",  imem_addr_o, 32'h0000_0300);
        chk("rg_req",   32'(imem_req_o), 32'h1);
        chk("rg_valid", 32'(instr_valid_o), 32'h0);

        // Misaligned redirect, then redirect to the top word and wrap.
        cycle(1'b1, 32'h0000_0203, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mis_pulse", 32'(misalign_o), 32'h1);
        chk("mis_addr",  imem_addr_o, 32'h0000_0200);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mis_clear", 32'(misalign_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        chk("mis_ipc", instr_pc_o, 32'h0000_0200);
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
        chk("top_ipc", instr_pc_o, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr", imem_addr_o, 32'h0000_0000);

        // Asynchronous reset while waiting for a response.
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("async_addr",  imem_addr_o, RP);
        chk("async_valid", 32'(instr_valid_o), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        chk("restart_addr", imem_addr_o, RP);
        chk("restart_req",  32'(imem_req_o), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom % 4 == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            cycle(($urandom % 8) == 0, tgt, ($urandom % 2) == 0,
                  ($urandom % 2) == 0, $urandom, ($urandom % 3) != 0);
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
